// File: rtl/scarv_uart_pkg.sv
// scarv_uart_pkg: definitions shared by the SCARV UART receiver and transmitter.
//   uart_rx_state_t : receiver FSM state encoding
//   uart_cpb()      : clocks per serial bit for a given clock and bit rate
//   UART_DATA_W     : payload width of one UART character
package scarv_uart_pkg;

    localparam int UART_DATA_W = 8;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_IDLE = 3'd4
    } uart_rx_state_t;

    // Integer division: any fractional clock per bit is dropped.
    function automatic int uart_cpb(input int clk_hz, input int bit_rate);
        return clk_hz / bit_rate;
    endfunction

endpackage

// File: rtl/scarv_uart_rx_if.sv
// scarv_uart_rx_if: single-entry valid/ready byte channel out of the UART receiver.
//   rx_data  : received byte, meaningful while rx_valid is high
//   rx_valid : the producer holds an unconsumed byte
//   rx_ready : the consumer takes rx_data on an edge where rx_valid && rx_ready
//   master   : producer side (the receiver); slave : consumer side
interface scarv_uart_rx_if;
    import scarv_uart_pkg::*;

    logic [UART_DATA_W-1:0] rx_data;
    logic                   rx_valid;
    logic                   rx_ready;

    modport master (output rx_data, output rx_valid, input rx_ready);
    modport slave  (input rx_data, input rx_valid, output rx_ready);

endinterface

// File: rtl/scarv_sync2.sv
// scarv_sync2: generic two-flop synchroniser for asynchronous single-bit inputs.
//   f_clk   : destination clock
//   g_reset : synchronous active-high reset, loads RST_VAL into both flops
//   d       : asynchronous input
//   q       : synchronised output, two cycles behind d
module scarv_sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic f_clk,
    input  logic g_reset,
    input  logic d,
    output logic q
);

    logic meta_r;
    logic sync_r;

    // Two-stage capture; the first stage may go metastable and is never used directly.
    always_ff @(posedge f_clk) begin
        if (g_reset) begin
            meta_r <= RST_VAL;
            sync_r <= RST_VAL;
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule

// File: rtl/scarv_uart_rx.sv
// scarv_uart_rx: UART receiver, 8 data bits LSB-first, no parity, 1 or 2 stop bits.
//   f_clk        : clock
//   g_reset      : synchronous active-high reset
//   uart_rxd     : asynchronous serial line, idles high
//   rx           : master side of the valid/ready byte channel (rx_data, rx_valid, rx_ready)
//   rx_overrun   : sticky, a received byte was dropped because the holding register was full
//   rx_frame_err : sticky, a stop bit was sampled low
//   err_clear    : clears both sticky flags; a coincident new error wins
module scarv_uart_rx
    import scarv_uart_pkg::*;
#(
    parameter int UART_BIT_RATE  = 256_000,
    parameter int UART_CLK_HZ    = 50_000_000,
    parameter int UART_STOP_BITS = 1
) (
    input  logic              f_clk,
    input  logic              g_reset,
    input  logic              uart_rxd,
    scarv_uart_rx_if.master   rx,
    output logic              rx_overrun,
    output logic              rx_frame_err,
    input  logic              err_clear
);

    localparam int CPB   = uart_cpb(UART_CLK_HZ, UART_BIT_RATE);
    localparam int HALF  = CPB / 2;
    localparam int CNT_W = $clog2(CPB);

    localparam logic [CNT_W-1:0] CNT_HALF_END = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] CNT_BIT_END  = CNT_W'(CPB - 1);
    localparam logic             STOP_LAST    = 1'(UART_STOP_BITS - 1);

    if (CPB < 4) begin : g_cpb_check
        $error("scarv_uart_rx: clocks per bit must be at least 4");
    end
    if ((UART_STOP_BITS != 1) && (UART_STOP_BITS != 2)) begin : g_stop_check
        $error("scarv_uart_rx: UART_STOP_BITS must be 1 or 2");
    end

    logic                   rxd_s;
    uart_rx_state_t         state_r, state_s;
    logic [CNT_W-1:0]       cnt_r, cnt_s;
    logic [2:0]             idx_r, idx_s;
    logic                   stop_idx_r, stop_idx_s;
    logic [UART_DATA_W-1:0] shift_r, shift_s;
    logic                   deliver_s;
    logic                   frame_err_s;
    logic [UART_DATA_W-1:0] data_r;
    logic                   valid_r;
    logic                   overrun_r;
    logic                   frame_err_r;

    scarv_sync2 #(.RST_VAL(1'b1)) u_sync (
        .f_clk   (f_clk),
        .g_reset (g_reset),
        .d       (uart_rxd),
        .q       (rxd_s)
    );

    // Frame-tracking state: FSM, bit-time counter, data/stop indices, shift register.
    always_ff @(posedge f_clk) begin
        if (g_reset) begin
            state_r    <= IDLE;
            cnt_r      <= '0;
            idx_r      <= 3'd0;
            stop_idx_r <= 1'b0;
            shift_r    <= '0;
        end else begin
            state_r    <= state_s;
            cnt_r      <= cnt_s;
            idx_r      <= idx_s;
            stop_idx_r <= stop_idx_s;
            shift_r    <= shift_s;
        end
    end

    // Next-state logic; every sample is taken from the synchronised line rxd_s.
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        idx_s       = idx_r;
        stop_idx_s  = stop_idx_r;
        shift_s     = shift_r;
        deliver_s   = 1'b0;
        frame_err_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (!rxd_s) begin
                    state_s = START;
                    cnt_s   = '0;
                end else begin
                    state_s = IDLE;
                end
            end
            START: begin
                // Re-check the line half a bit in; a high here was only a glitch.
                if (cnt_r == CNT_HALF_END) begin
                    cnt_s = '0;
                    if (!rxd_s) begin
                        state_s = DATA;
                        idx_s   = 3'd0;
                    end else begin
                        state_s = IDLE;
                    end
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
            end
            DATA: begin
                // Shift right so the first (LSB) bit ends up at bit 0 after eight samples.
                if (cnt_r == CNT_BIT_END) begin
                    cnt_s   = '0;
                    shift_s = {rxd_s, shift_r[UART_DATA_W-1:1]};
                    idx_s   = idx_r + 3'd1;
                    if (idx_r == 3'd7) begin
                        state_s    = STOP;
                        stop_idx_s = 1'b0;
                    end else begin
                        state_s = DATA;
                    end
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
            end
            STOP: begin
                if (cnt_r == CNT_BIT_END) begin
                    cnt_s = '0;
                    if (rxd_s) begin
                        if (stop_idx_r == STOP_LAST) begin
                            deliver_s = 1'b1;
                            state_s   = IDLE;
                        end else begin
                            stop_idx_s = stop_idx_r + 1'b1;
                        end
                    end else begin
                        frame_err_s = 1'b1;
                        state_s     = WAIT_IDLE;
                    end
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
            end
            WAIT_IDLE: begin
                // Hold off through a break so a long low never decodes as frames.
                if (rxd_s) begin
                    state_s = IDLE;
                end else begin
                    state_s = WAIT_IDLE;
                end
            end
            default: begin
                state_s = IDLE;
                cnt_s   = '0;
            end
        endcase
    end

    // Holding register and sticky error flags.
    always_ff @(posedge f_clk) begin
        if (g_reset) begin
            data_r      <= '0;
            valid_r     <= 1'b0;
            overrun_r   <= 1'b0;
            frame_err_r <= 1'b0;
        end else begin
            // A delivery coinciding with a consume refills the register in the same edge.
            if (deliver_s && (!valid_r || rx.rx_ready)) begin
                data_r  <= shift_r;
                valid_r <= 1'b1;
            end else if (valid_r && rx.rx_ready) begin
                valid_r <= 1'b0;
            end else begin
                valid_r <= valid_r;
            end

            if (deliver_s && valid_r && !rx.rx_ready) begin
                overrun_r <= 1'b1;
            end else if (err_clear) begin
                overrun_r <= 1'b0;
            end else begin
                overrun_r <= overrun_r;
            end

            if (frame_err_s) begin
                frame_err_r <= 1'b1;
            end else if (err_clear) begin
                frame_err_r <= 1'b0;
            end else begin
                frame_err_r <= frame_err_r;
            end
        end
    end

    assign rx.rx_data   = data_r;
    assign rx.rx_valid  = valid_r;
    assign rx_overrun   = overrun_r;
    assign rx_frame_err = frame_err_r;

endmodule
